// File: rtl/cc_tag_ctrl_pkg.sv
// rtl/cc_tag_ctrl_pkg.sv - shared constants and types for the code-cache tag controller
package cc_tag_ctrl_pkg;

  // Large-icache build doubles the number of sets.
  localparam bit ICACHE_256K = 1'b0;
  localparam int PHYS_BITS   = 44;

  localparam int CC_TAG_ADDR_WIDTH   = ICACHE_256K ? 8 : 7;
  localparam int CC_TAG_SETS         = 1 << CC_TAG_ADDR_WIDTH;
  localparam int CC1TAG_PADDR_W      = PHYS_BITS - 7;
  localparam int CC_TAG_STARVE_LIMIT = 15;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } cc_tag_state_e;

endpackage

// File: rtl/cc_tag_ctrl_if.sv
// rtl/cc_tag_ctrl_if.sv - requester and tag-way signal bundle for the tag controller
interface cc_tag_ctrl_if
  import cc_tag_ctrl_pkg::*;
#(
  parameter int PADDR_W = CC1TAG_PADDR_W
) ();

  logic               flush_req;
  logic               fetch_req;
  logic [PADDR_W-1:0] fetch_addr;
  logic               fetch_gnt;
  logic               fill_req;
  logic [PADDR_W-1:0] fill_addr;
  logic               fill_gnt;
  logic               inv_req;
  logic [PADDR_W-1:0] inv_addr;
  logic               inv_gnt;
  logic               tag_read_clkEn;
  logic [PADDR_W-1:0] tag_read_addr;
  logic               tag_write_wen;
  logic               tag_invalidate;
  logic [PADDR_W-1:0] tag_write_addr;
  logic               tag_init;
  logic               ready;

  modport master (
    output flush_req, fetch_req, fetch_addr, fill_req, fill_addr, inv_req, inv_addr,
    input  fetch_gnt, fill_gnt, inv_gnt, tag_read_clkEn, tag_read_addr,
           tag_write_wen, tag_invalidate, tag_write_addr, tag_init, ready
  );

  modport slave (
    input  flush_req, fetch_req, fetch_addr, fill_req, fill_addr, inv_req, inv_addr,
    output fetch_gnt, fill_gnt, inv_gnt, tag_read_clkEn, tag_read_addr,
           tag_write_wen, tag_invalidate, tag_write_addr, tag_init, ready
  );

endinterface

// File: rtl/cc_tag_ctrl_wr_arb.sv
// rtl/cc_tag_ctrl_wr_arb.sv - tag write-port arbiter: inv/fill priority, fill anti-starvation, same-set bubble
module cc_tag_ctrl_wr_arb
  import cc_tag_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = CC_TAG_ADDR_WIDTH,
  parameter int STARVE_LIMIT = CC_TAG_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_inv_req,
  input  logic [ADDR_WIDTH-1:0] i_inv_idx,
  input  logic                  i_fill_req,
  input  logic [ADDR_WIDTH-1:0] i_fill_idx,
  output logic                  o_inv_gnt,
  output logic                  o_fill_gnt,
  output logic                  o_last_wr_valid,
  output logic [ADDR_WIDTH-1:0] o_last_wr_idx
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]         r_starve;
  logic                  r_last_wr_valid;
  logic [ADDR_WIDTH-1:0] r_last_wr_idx;
  logic                  w_inv_ok;
  logic                  w_fill_ok;
  logic                  w_starved;
  logic                  w_inv_gnt;
  logic                  w_fill_gnt;

  // Mask requests hitting the set written last cycle, then pick one winner (inv first unless fill is starved).
  always_comb begin
    w_inv_ok   = i_en & i_inv_req  & ~(r_last_wr_valid & (i_inv_idx  == r_last_wr_idx));
    w_fill_ok  = i_en & i_fill_req & ~(r_last_wr_valid & (i_fill_idx == r_last_wr_idx));
    w_starved  = (r_starve == SW'(STARVE_LIMIT));
    w_fill_gnt = w_fill_ok & (w_starved | ~w_inv_ok);
    w_inv_gnt  = w_inv_ok & ~w_fill_gnt;
  end

  // Count cycles a pending fill goes unserved; saturate so the limit compare stays true until it wins.
  always_ff @(negedge clk) begin
    if (rst || !i_en || w_fill_gnt) begin
      r_starve <= '0;
    end else if (i_fill_req && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Remember the set of this cycle's write; a cycle with no write clears it so the next cycle is free.
  always_ff @(negedge clk) begin
    if (rst || !i_en) begin
      r_last_wr_valid <= 1'b0;
      r_last_wr_idx   <= '0;
    end else begin
      r_last_wr_valid <= w_inv_gnt | w_fill_gnt;
      if (w_inv_gnt) begin
        r_last_wr_idx <= i_inv_idx;
      end else if (w_fill_gnt) begin
        r_last_wr_idx <= i_fill_idx;
      end
    end
  end

  assign o_inv_gnt       = w_inv_gnt;
  assign o_fill_gnt      = w_fill_gnt;
  assign o_last_wr_valid = r_last_wr_valid;
  assign o_last_wr_idx   = r_last_wr_idx;

endmodule

// File: rtl/cc_tag_ctrl.sv
// rtl/cc_tag_ctrl.sv - code-cache tag sequencer: init sweep, then read/write port sharing with hazard bubbles
module cc_tag_ctrl
  import cc_tag_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = CC_TAG_ADDR_WIDTH,
  parameter int ADDR_COUNT   = CC_TAG_SETS,
  parameter int PADDR_W      = CC1TAG_PADDR_W,
  parameter int STARVE_LIMIT = CC_TAG_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          rst,
  cc_tag_ctrl_if.slave  bus
);

  cc_tag_state_e         r_state;
  cc_tag_state_e         w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [PADDR_W-1:0]    r_wr_addr;
  logic [PADDR_W-1:0]    r_rd_addr;
  logic [PADDR_W-1:0]    w_wr_addr;
  logic [PADDR_W-1:0]    w_rd_addr;
  logic                  w_run;
  logic                  w_sweep_last;
  logic                  w_tag_init;
  logic                  w_fetch_hit;
  logic                  w_fetch_gnt;
  logic                  w_inv_gnt;
  logic                  w_fill_gnt;
  logic                  w_last_wr_valid;
  logic [ADDR_WIDTH-1:0] w_last_wr_idx;

  assign w_run        = (r_state == ST_RUN);
  assign w_sweep_last = (r_cnt == ADDR_WIDTH'(ADDR_COUNT - 1));
  assign w_fetch_hit  = w_last_wr_valid & (bus.fetch_addr[ADDR_WIDTH-1:0] == w_last_wr_idx);

  cc_tag_ctrl_wr_arb #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_wr_arb (
    .clk             (clk),
    .rst             (rst),
    .i_en            (w_run),
    .i_inv_req       (bus.inv_req),
    .i_inv_idx       (bus.inv_addr[ADDR_WIDTH-1:0]),
    .i_fill_req      (bus.fill_req),
    .i_fill_idx      (bus.fill_addr[ADDR_WIDTH-1:0]),
    .o_inv_gnt       (w_inv_gnt),
    .o_fill_gnt      (w_fill_gnt),
    .o_last_wr_valid (w_last_wr_valid),
    .o_last_wr_idx   (w_last_wr_idx)
  );

  // State register; tag arrays update on the falling edge so this does too.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Leave the sweep after the last set is issued; a flush always goes back to the start of a sweep.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT: if (!bus.flush_req && w_sweep_last) w_next_state = ST_RUN;
      ST_RUN:  if (bus.flush_req) w_next_state = ST_INIT;
      default: w_next_state = ST_INIT;
    endcase
  end

  // Sweep index: advances only while sweeping, and sits at zero ready for the next sweep otherwise.
  always_ff @(negedge clk) begin
    if (rst || r_state != ST_INIT || bus.flush_req || w_sweep_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  // Port outputs: init strobe while sweeping; in run, the read grant and the write winner's address.
  always_comb begin
    w_tag_init  = 1'b0;
    w_fetch_gnt = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_rd_addr   = r_rd_addr;
    case (r_state)
      ST_INIT: begin
        w_tag_init = 1'b1;
        w_wr_addr  = PADDR_W'(r_cnt);
      end
      ST_RUN: begin
        w_fetch_gnt = bus.fetch_req & ~w_fetch_hit;
        if (w_fetch_gnt) w_rd_addr = bus.fetch_addr;
        if (w_inv_gnt) begin
          w_wr_addr = bus.inv_addr;
        end else if (w_fill_gnt) begin
          w_wr_addr = bus.fill_addr;
        end
      end
      default: w_tag_init = 1'b0;
    endcase
  end

  // Addresses hold their last issued value while the port is idle.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else begin
      r_wr_addr <= w_wr_addr;
      r_rd_addr <= w_rd_addr;
    end
  end

  assign bus.fetch_gnt      = w_fetch_gnt;
  assign bus.fill_gnt       = w_fill_gnt;
  assign bus.inv_gnt        = w_inv_gnt;
  assign bus.tag_read_clkEn = w_fetch_gnt;
  assign bus.tag_read_addr  = w_rd_addr;
  assign bus.tag_write_wen  = w_fill_gnt;
  assign bus.tag_invalidate = w_inv_gnt;
  assign bus.tag_write_addr = w_wr_addr;
  assign bus.tag_init       = w_tag_init;
  assign bus.ready          = w_run;

endmodule

// File: tb/tb_cc_tag_ctrl.sv
// tb/tb_cc_tag_ctrl.sv - self-checking bench for cc_tag_ctrl
module tb_cc_tag_ctrl;

  localparam int AW    = 37;
  localparam int NSETS = 128;

  typedef struct {
    logic          rst;
    logic          flush;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fill_req;
    logic [AW-1:0] fill_addr;
    logic          inv_req;
    logic [AW-1:0] inv_addr;
  } stim_t;

  // flags = {ready, tag_init, fetch_gnt, fill_gnt, inv_gnt, tag_read_clkEn, tag_write_wen, tag_invalidate}
  typedef struct {
    string         name;
    logic [7:0]    flags;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t tbl[11];

  always #5 clk = ~clk;

  cc_tag_ctrl_if bus ();

  cc_tag_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic stim_t st(input logic fe, input logic [AW-1:0] fa,
                               input logic fi, input logic [AW-1:0] la,
                               input logic iv, input logic [AW-1:0] ia);
    stim_t s;
    s.rst = 1'b0; s.flush = 1'b0;
    s.fetch_req = fe; s.fetch_addr = fa;
    s.fill_req  = fi; s.fill_addr  = la;
    s.inv_req   = iv; s.inv_addr   = ia;
    return s;
  endfunction

  function automatic exp_t ex(input string nm, input logic [7:0] fl,
                              input logic [AW-1:0] wa, input logic [AW-1:0] ra);
    exp_t e;
    e.name = nm; e.flags = fl; e.waddr = wa; e.raddr = ra;
    return e;
  endfunction

  function automatic vec_t mkv(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s; v.e = e;
    return v;
  endfunction

  task automatic check_out();
    exp_t       e;
    logic [7:0] act;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard: output sampled with no expected entry queued");
      return;
    end
    e   = sb_q.pop_front();
    act = {bus.ready, bus.tag_init, bus.fetch_gnt, bus.fill_gnt, bus.inv_gnt,
           bus.tag_read_clkEn, bus.tag_write_wen, bus.tag_invalidate};
    n_vec++;
    if (act !== e.flags || bus.tag_write_addr !== e.waddr || bus.tag_read_addr !== e.raddr) begin
      n_miss++;
      $display("FAIL %s: got flags=%b waddr=%h raddr=%h, expected flags=%b waddr=%h raddr=%h",
               e.name, act, bus.tag_write_addr, bus.tag_read_addr, e.flags, e.waddr, e.raddr);
    end
  endtask

  // One clock cycle: drive after the rising edge, sample well before the falling (active) edge.
  task automatic apply(input stim_t s, input exp_t e, input bit chk);
    @(posedge clk);
    #1;
    rst            = s.rst;
    bus.flush_req  = s.flush;
    bus.fetch_req  = s.fetch_req;
    bus.fetch_addr = s.fetch_addr;
    bus.fill_req   = s.fill_req;
    bus.fill_addr  = s.fill_addr;
    bus.inv_req    = s.inv_req;
    bus.inv_addr   = s.inv_addr;
    if (chk) sb_q.push_back(e);
    #1;
    if (chk) check_out();
  endtask

  // Full init sweep with a fetch held; optionally assert rst in the cycle showing index stop_at.
  task automatic sweep(input int stop_at, input logic [AW-1:0] fa,
                       input logic [AW-1:0] rhold, input string tag);
    stim_t s;
    s = st(1'b1, fa, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < NSETS; i++) begin
      s.rst = (i == stop_at);
      apply(s, ex($sformatf("%s_init%0d", tag, i), 8'b0100_0000, AW'(i), rhold), 1'b1);
      if (i == stop_at) return;
    end
    s.rst = 1'b0;
    apply(s, ex({tag, "_ready"}, 8'b1010_0100, AW'(NSETS - 1), fa), 1'b1);
  endtask

  initial begin
    stim_t s;
    bus.flush_req  = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.fill_req   = 1'b0;
    bus.fill_addr  = '0;
    bus.inv_req    = 1'b0;
    bus.inv_addr   = '0;

    s = st(1'b1, 37'h1_0000_0003, 1'b0, '0, 1'b0, '0);
    s.rst = 1'b1;
    apply(s, ex("rst", 8'h00, '0, '0), 1'b0);
    sweep(-1, 37'h1_0000_0003, '0, "sweep0");

    tbl[0]  = mkv(st(1, 37'h145, 1, 37'h1F_0000_0045, 0, '0),
                  ex("fill_fetch_same_set", 8'b1011_0110, 37'h1F_0000_0045, 37'h145));
    tbl[1]  = mkv(st(1, 37'h245, 0, '0, 0, '0),
                  ex("fetch_bubble", 8'b1000_0000, 37'h1F_0000_0045, 37'h145));
    tbl[2]  = mkv(st(1, 37'h245, 0, '0, 0, '0),
                  ex("fetch_after_bubble", 8'b1010_0100, 37'h1F_0000_0045, 37'h245));
    tbl[3]  = mkv(st(0, '0, 0, '0, 1, 37'h0A_0000_0010),
                  ex("inv_0x10", 8'b1000_1001, 37'h0A_0000_0010, 37'h245));
    tbl[4]  = mkv(st(0, '0, 1, 37'h10, 0, '0),
                  ex("fill_0x10_blocked", 8'b1000_0000, 37'h0A_0000_0010, 37'h245));
    tbl[5]  = mkv(st(0, '0, 1, 37'h10, 0, '0),
                  ex("fill_0x10_gnt", 8'b1001_0010, 37'h10, 37'h245));
    tbl[6]  = mkv(st(0, '0, 1, 37'h22, 1, 37'h90),
                  ex("inv_masked_fill_wins", 8'b1001_0010, 37'h22, 37'h245));
    tbl[7]  = mkv(st(1, 37'h1A2, 0, '0, 1, 37'h90),
                  ex("inv_gnt_fetch_masked", 8'b1000_1001, 37'h90, 37'h245));
    tbl[8]  = mkv(st(1, 37'h22, 1, 37'h44, 1, 37'h33),
                  ex("inv_over_fill_plus_fetch", 8'b1010_1101, 37'h33, 37'h22));
    tbl[9]  = mkv(st(0, '0, 1, 37'h44, 0, '0),
                  ex("fill_after_loss", 8'b1001_0010, 37'h44, 37'h22));
    tbl[10] = mkv(st(0, '0, 0, '0, 0, '0),
                  ex("idle_hold", 8'b1000_0000, 37'h44, 37'h22));
    foreach (tbl[i]) apply(tbl[i].s, tbl[i].e, 1'b1);

    for (int k = 1; k <= 32; k++) begin
      logic [AW-1:0] ia;
      ia = (k % 2 == 1) ? 37'h5_0000_0020 : 37'h5_0000_0021;
      s  = st(0, '0, 1, 37'h30, 1, ia);
      if (k == 16 || k == 32)
        apply(s, ex($sformatf("starve%0d_fill", k), 8'b1001_0010, 37'h30, 37'h22), 1'b1);
      else
        apply(s, ex($sformatf("starve%0d_inv", k), 8'b1000_1001, ia, 37'h22), 1'b1);
    end
    apply(st(0, '0, 0, '0, 0, '0), ex("idle_after_starve", 8'b1000_0000, 37'h30, 37'h22), 1'b1);

    s = st(1, 37'h55, 1, 37'h66, 0, '0);
    s.flush = 1'b1;
    apply(s, ex("flush_same_cycle_gnts", 8'b1011_0110, 37'h66, 37'h55), 1'b1);
    sweep(-1, 37'h55, 37'h55, "sweep1");

    s = st(1, 37'h77, 0, '0, 0, '0);
    s.flush = 1'b1;
    apply(s, ex("flush2", 8'b1010_0100, 37'h7F, 37'h77), 1'b1);
    sweep(60, 37'h77, 37'h77, "sweep2");
    sweep(-1, 37'h77, '0, "sweep3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
